// File: rtl/ripple_count_monitor.sv
// ---------------------------------------------------------------------------
// ripple_count_monitor: synchronizes and filters a ripple-counter value, then
// tracks wraps (epoch), match events and non-unit steps.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ripple_count_monitor #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EPOCH_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   count_in,
  input  logic [WIDTH-1:0]   match_val,
  input  logic               clr,
  output logic [WIDTH-1:0]   count_stable,
  output logic               valid,
  output logic               wrap_pulse,
  output logic               match_pulse,
  output logic [EPOCH_W-1:0] epoch,
  output logic               skip_err
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_TRACK = 1'b1;
  localparam logic [WIDTH-1:0] MAX_CNT  = '1;

  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   sync_d [SYNC_STAGES];
  logic [SYNC_STAGES:0] prime_q, prime_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   count_stable_q, count_stable_d;
  logic               valid_q, valid_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic               match_pulse_q, match_pulse_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               skip_err_q, skip_err_d;

  logic [WIDTH-1:0]   s;
  logic [WIDTH-1:0]   step;
  logic               candidate;
  logic               update;

  assign s    = sync_q[SYNC_STAGES-1];
  assign step = s - count_stable_q;
  // prime_q tracks which pipeline stages hold real samples since reset, so the
  // reset-cleared chain contents are never mistaken for a settled count.
  assign candidate = (s == f_q) && prime_q[SYNC_STAGES];
  assign update    = candidate && (s != count_stable_q);

  always_comb begin
    sync_d[0] = count_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
    f_d     = s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prime_q <= '0;
      f_q     <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prime_q <= prime_d;
      f_q     <= f_d;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE && candidate) begin
      state_d = ST_TRACK;
    end
  end

  // Output logic
  always_comb begin
    count_stable_d = count_stable_q;
    valid_d        = valid_q;
    wrap_pulse_d   = 1'b0;
    match_pulse_d  = 1'b0;
    epoch_d        = epoch_q;
    skip_err_d     = skip_err_q;
    if (clr) begin
      count_stable_d = '0;
      valid_d        = 1'b0;
      epoch_d        = '0;
      skip_err_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (candidate) begin
            count_stable_d = s;
            valid_d        = 1'b1;
          end
        end
        default: begin
          if (update) begin
            count_stable_d = s;
            match_pulse_d  = (s == match_val);
            if (step == WIDTH'(1)) begin
              if (count_stable_q == MAX_CNT) begin
                wrap_pulse_d = 1'b1;
                epoch_d      = epoch_q + EPOCH_W'(1);
              end
            end else begin
              skip_err_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_stable_q <= '0;
      valid_q        <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      match_pulse_q  <= 1'b0;
      epoch_q        <= '0;
      skip_err_q     <= 1'b0;
    end else begin
      count_stable_q <= count_stable_d;
      valid_q        <= valid_d;
      wrap_pulse_q   <= wrap_pulse_d;
      match_pulse_q  <= match_pulse_d;
      epoch_q        <= epoch_d;
      skip_err_q     <= skip_err_d;
    end
  end

  assign count_stable = count_stable_q;
  assign valid        = valid_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign match_pulse  = match_pulse_q;
  assign epoch        = epoch_q;
  assign skip_err     = skip_err_q;

endmodule

`default_nettype wire
